sort_4x4_sequencer: RTL and testbench

Sequential sorter for four 4-bit elements packed in a 16-bit word. It reuses a single compare-exchange unit across the five steps of the 4-input sorting network, so one sort takes five compare cycles. It sits between a valid/ready producer and a valid/ready consumer wherever the fully combinational five-comparator sorter costs too much area.

---
 rtl/sort_pkg.sv | 24 ++
 rtl/cmp_exchange.sv | 14 +
 rtl/sort_4x4_sequencer.sv | 95 +++++++++
 tb/tb_sort_4x4_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and the compare-exchange schedule for the 4-element sequential sorter.
package sort_pkg;
  localparam int ELEM_W = 4;
  localparam int NUM_EL = 4;
  localparam int STEPS  = 5;

  typedef logic [ELEM_W-1:0] elem_t;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  typedef struct packed {
    logic [1:0] hi;
    logic [1:0] lo;
  } pair_t;

  // Entry k is the (hi, lo) element pair exchanged at step k; step 0 in the low nibble.
  localparam logic [STEPS-1:0][3:0] SCHED = {
    4'b10_01,  // step 4: (2,1)
    4'b10_00,  // step 3: (2,0)
    4'b11_01,  // step 2: (3,1)
    4'b01_00,  // step 1: (1,0)
    4'b11_10   // step 0: (3,2)
  };
endpackage

// File: rtl/cmp_exchange.sv
// Combinational compare-exchange: larger operand on hi, smaller on lo; equal never swaps.
module cmp_exchange #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         swapped
);
  assign swapped = (a < b);
  assign hi      = swapped ? b : a;
  assign lo      = swapped ? a : b;
endmodule

// File: rtl/sort_4x4_sequencer.sv
// Sequential descending sorter for four W-bit elements using one shared compare-exchange.
// Define SORT_STATS_EN to add the swaps exchange counter port.
module sort_4x4_sequencer
  import sort_pkg::*;
#(
  parameter int W = ELEM_W
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] out_data,
  output logic           busy
`ifdef SORT_STATS_EN
  ,
  output logic [2:0]     swaps
`endif
);
  state_t state, state_n;
  logic [NUM_EL-1:0][W-1:0] e;
  logic [2:0]               step;
  logic                     accept;
  pair_t                    pr;
  logic [W-1:0]             x_hi, x_lo;
  logic                     x_sw;

  assign pr = pair_t'(SCHED[step]);

  cmp_exchange #(.W(W)) u_cx (
    .a       (e[pr.hi]),
    .b       (e[pr.lo]),
    .hi      (x_hi),
    .lo      (x_lo),
    .swapped (x_sw)
  );

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  // in_ready is gated by nrst so the reset cycle never advertises readiness.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = nrst;
        if (in_valid && nrst) begin
          accept  = 1'b1;
          state_n = CMP;
        end
      end
      CMP: begin
        busy = 1'b1;
        if (step == 3'(STEPS-1)) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      e    <= '0;
      step <= '0;
    end else if (accept) begin
      e    <= in_data;
      step <= '0;
    end else if (state == CMP) begin
      e[pr.hi] <= x_hi;
      e[pr.lo] <= x_lo;
      if (step != 3'(STEPS-1)) step <= step + 3'd1;
    end
  end

  assign out_data = e;

`ifdef SORT_STATS_EN
  always_ff @(posedge clk) begin
    if (!nrst)                       swaps <= '0;
    else if (accept)                 swaps <= '0;
    else if (state == CMP && x_sw)   swaps <= swaps + 3'd1;
  end
`endif
endmodule

// File: tb/tb_sort_4x4_sequencer.sv
// Scoreboarded bench for sort_4x4_sequencer; swaps checks compile in with SORT_STATS_EN.
module tb_sort_4x4_sequencer;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_data;
`ifdef SORT_STATS_EN
  logic [2:0]  swaps;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [15:0] sb[$];

  sort_4x4_sequencer #(.W(4)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef SORT_STATS_EN
    ,
    .swaps     (swaps)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_sort(input logic [15:0] w);
    logic [3:0] v [4];
    logic [3:0] t;
    for (int i = 0; i < 4; i++) v[i] = w[i*4 +: 4];
    for (int i = 1; i < 4; i++)
      for (int j = i; j > 0 && v[j-1] < v[j]; j--) begin
        t = v[j]; v[j] = v[j-1]; v[j-1] = t;
      end
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Scoreboard monitor: samples on the falling edge, between input updates and the active edge.
  always @(negedge clk) begin
    logic [15:0] exp;
    if (!nrst) sb.delete();
    else begin
      if (in_valid && in_ready) sb.push_back(ref_sort(in_data));
      if (out_valid && out_ready) begin
        n_tests++;
        n_out++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: out_data=%h but no word outstanding", out_data);
        end else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin
            n_fail++;
            $display("FAIL sb_data: got %h expected %h", out_data, exp);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
    step(); step();
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b expected 0 0 0",
               in_ready, out_valid, busy);
    end
    in_valid = 1'b0;
    nrst = 1'b1;
    step();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b busy=%b out_data=%h expected 1 0 0 0000",
               in_ready, out_valid, busy, out_data);
    end
`ifdef SORT_STATS_EN
    n_tests++;
    if (swaps !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_swaps: got %0d expected 0", swaps);
    end
`endif
  endtask

  task automatic test_sort(input logic [15:0] w, input logic [15:0] exp_w,
                           input int exp_sw, input string nm);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin step(); k++; end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL %s_ready: in_ready=%b expected 1", nm, in_ready);
    end
    in_data = w; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy: busy=%b in_ready=%b expected 1 0", nm, busy, in_ready);
    end
    k = 0;
    while (!out_valid && k < 20) begin step(); k++; end
    n_tests++;
    if (k !== 5) begin
      n_fail++;
      $display("FAIL %s_latency: out_valid after %0d cycles expected 5", nm, k);
    end
    n_tests++;
    if (out_data !== exp_w) begin
      n_fail++;
      $display("FAIL %s_data: got %h expected %h", nm, out_data, exp_w);
    end
`ifdef SORT_STATS_EN
    n_tests++;
    if (swaps !== 3'(exp_sw)) begin
      n_fail++;
      $display("FAIL %s_swaps: got %0d expected %0d", nm, swaps, exp_sw);
    end
`endif
    step();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_return_idle: out_valid=%b in_ready=%b expected 0 1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int k;
    logic [15:0] d0;
    in_data = 16'h1234; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_data = 16'h0F0F;  // held high during the sort and must be ignored
    k = 0;
    while (!out_valid && k < 20) begin step(); k++; end
    d0 = out_data;
    n_tests++;
    if (d0 !== 16'h4321) begin
      n_fail++;
      $display("FAIL bp_data: got %h expected 4321", d0);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== d0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out_data=%h expected 1 0 %h",
                 i, out_valid, in_ready, out_data, d0);
      end
`ifdef SORT_STATS_EN
      n_tests++;
      if (swaps !== 3'd4) begin
        n_fail++;
        $display("FAIL bp_swaps[%0d]: got %0d expected 4", i, swaps);
      end
`endif
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midsort();
    in_data = 16'h1234; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();          // steps 0 and 1 done; step 2 is next
    nrst = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: busy=%b out_valid=%b in_ready=%b expected 0 0 0",
               busy, out_valid, in_ready);
    end
    nrst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_no_output[%0d]: out_valid=%b busy=%b expected 0 0", i, out_valid, busy);
      end
    end
    test_sort(16'h3A5C, 16'hCA53, 5, "after_rst");
  endtask

  task automatic test_back_to_back();
    int acc, cyc, last, k, out0;
    out0 = n_out;
    acc = 0; cyc = 0; last = -1;
    out_ready = 1'b1;
    in_data = 16'($urandom);
    in_valid = 1'b1;
    while (acc < 8 && cyc < 200) begin
      if (in_ready) begin
        if (last >= 0) begin
          n_tests++;
          if (cyc - last !== 7) begin
            n_fail++;
            $display("FAIL b2b_period[%0d]: accept spacing %0d expected 7", acc, cyc - last);
          end
        end
        last = cyc;
        acc++;
        step(); cyc++;
        in_data = 16'($urandom);
      end else begin
        step(); cyc++;
      end
    end
    in_valid = 1'b0;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 50) begin step(); k++; end
    n_tests++;
    if (acc !== 8 || sb.size() != 0 || n_out - out0 !== 8) begin
      n_fail++;
      $display("FAIL b2b_count: accepted %0d outputs %0d pending %0d expected 8 8 0",
               acc, n_out - out0, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_sort(16'h1234, 16'h4321, 4, "s1234");
    test_sort(16'h4321, 16'h4321, 0, "s4321");
    test_sort(16'hFFFF, 16'hFFFF, 0, "sFFFF");
    test_sort(16'h0F0F, 16'hFF00, 3, "s0F0F");
    test_backpressure();
    test_reset_midsort();
    test_back_to_back();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d words outstanding expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
